// File: rtl/gpr_pkg.sv
// Shared types and helpers for the multi-port GPR file.
package gpr_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } gpr_state_e;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 32;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gpr_rdport.sv
// One combinational read port: clear/reset masking, zero register, then write bypass.
module gpr_rdport
    import gpr_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             rst,
    input  gpr_state_e       state,
    input  logic [AW-1:0]    ra_k,
    input  logic [XLEN-1:0]  mem_word,
    input  logic             we,
    input  logic [AW-1:0]    rd,
    input  logic [XLEN-1:0]  di,
    output logic [XLEN-1:0]  qa_k
);

    always_comb begin
        qa_k = mem_word;
        if (rst || state == CLEAR) begin
            qa_k = '0;
        end else if (ZERO_REG != 0 && ra_k == '0) begin
            qa_k = '0;
        end else if (BYPASS != 0 && we && ra_k == rd) begin
            qa_k = di;
        end
    end

endmodule

// File: rtl/gpr_mp.sv
// Multi-read-port register file with a one-entry-per-cycle clear sequencer after reset.
module gpr_mp
    import gpr_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [AW-1:0]           rd,
    input  logic [XLEN-1:0]         di,
    input  logic [NREAD*AW-1:0]     ra,
    output logic [NREAD*XLEN-1:0]   qa,
    output logic                    ready
);

    logic [XLEN-1:0] mem [DEPTH];

    gpr_state_e      state_reg;
    logic [AW-1:0]   cp_reg;
    logic            ready_reg;

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;

    // Clear sequencer: after reset, sweep every address before accepting traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CLEAR;
            cp_reg    <= '0;
            ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    cp_reg <= cp_reg + AW'(1);
                    if (cp_reg == AW'(DEPTH - 1)) begin
                        state_reg <= RUN;
                        ready_reg <= 1'b1;
                    end
                end
                RUN: begin
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= CLEAR;
                    cp_reg    <= '0;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    // Single write port shared by the clear sweep and normal writeback.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = rd;
        wr_data = di;
        if (!rst) begin
            if (state_reg == CLEAR) begin
                wr_en   = 1'b1;
                wr_addr = cp_reg;
                wr_data = '0;
            end else if (we && !(ZERO_REG != 0 && rd == '0)) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign ready = ready_reg;

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [AW-1:0]   ra_k;
        logic [XLEN-1:0] word;

        assign ra_k = ra[gi*AW +: AW];
        assign word = mem[ra_k];

        gpr_rdport #(
            .XLEN     (XLEN),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rdport (
            .rst      (rst),
            .state    (state_reg),
            .ra_k     (ra_k),
            .mem_word (word),
            .we       (we),
            .rd       (rd),
            .di       (di),
            .qa_k     (qa[gi*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_gpr_mp.sv
// Bench for gpr_mp: directed clear/bypass/parameter sequences, a vector table and a randomized model regression.
module tb_gpr_mp;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] di;
    logic [9:0]  ra;
    logic [63:0] qa_a;
    logic [63:0] qa_b;
    logic        ready_a;
    logic        ready_b;

    logic         rst_c;
    logic         we_c;
    logic [3:0]   rd_c;
    logic [63:0]  di_c;
    logic [11:0]  ra_c;
    logic [191:0] qa_c;
    logic         ready_c;

    int n_tests;
    int n_fail;

    // reference model: register contents plus number of clear cycles still to run
    logic [31:0] mdl_mem [32];
    int          clear_left;

    gpr_mp #(.XLEN(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .we(we), .rd(rd), .di(di), .ra(ra), .qa(qa_a), .ready(ready_a)
    );

    gpr_mp #(.XLEN(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .we(we), .rd(rd), .di(di), .ra(ra), .qa(qa_b), .ready(ready_b)
    );

    gpr_mp #(.XLEN(64), .DEPTH(16), .NREAD(3), .ZERO_REG(0), .BYPASS(1)) dut_c (
        .clk(clk), .rst(rst_c), .we(we_c), .rd(rd_c), .di(di_c), .ra(ra_c), .qa(qa_c), .ready(ready_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] di;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp_a0;
        logic [31:0] exp_a1;
        logic [31:0] exp_b0;
        logic [31:0] exp_b1;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
        if (rst || clear_left > 0) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (byp && we && a == rd) return di;
        return mdl_mem[a];
    endfunction

    task automatic model_update();
        if (rst) begin
            clear_left = 32;
        end else if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0) begin
                for (int i = 0; i < 32; i++) mdl_mem[i] = 32'h0;
            end
        end else if (we && rd != 5'd0) begin
            mdl_mem[rd] = di;
        end
    endtask

    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            chk("mdl_qa_byp", {32'h0, qa_a[k*32 +: 32]}, {32'h0, exp_rd(1'b1, ra[k*5 +: 5])});
            chk("mdl_qa_nobyp", {32'h0, qa_b[k*32 +: 32]}, {32'h0, exp_rd(1'b0, ra[k*5 +: 5])});
        end
        chk("mdl_ready_a", {63'h0, ready_a}, 64'(clear_left == 0));
        chk("mdl_ready_b", {63'h0, ready_b}, 64'(clear_left == 0));
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_left = 32;
        for (int i = 0; i < 32; i++) mdl_mem[i] = 32'h0;

        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd3, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[4] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        vecs[5] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[6] = '{1'b1, 5'd7, 32'h11111111, 5'd7, 5'd7, 32'h11111111, 32'h11111111, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[7] = '{1'b0, 5'd0, 32'h0,        5'd31, 5'd7, 32'h0,       32'h11111111, 32'h0,        32'h11111111};

        clk = 1'b0;
        rst = 1'b1;  we = 1'b0;  rd = '0;  di = '0;  ra = '0;
        rst_c = 1'b1; we_c = 1'b0; rd_c = '0; di_c = '0; ra_c = '0;

        // reset held for three edges, then a full clear sweep
        @(posedge clk);
        model_update();
        #1;
        step();
        step();
        rst = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            ra = 10'($urandom);
            #1;
            chk("clr_ready", {63'h0, ready_a}, 64'(i == 33));
            if (i < 33) begin
                chk("clr_qa_a", qa_a, 64'h0);
                chk("clr_qa_b", qa_b, 64'h0);
            end
            step();
        end
        $display("[TB] clear sweep: ready observed after 32 clear cycles");

        for (int a = 0; a < 32; a += 2) begin
            ra = {5'(a + 1), 5'(a)};
            #1;
            chk("clr_readall_a", qa_a, 64'h0);
            chk("clr_readall_b", qa_b, 64'h0);
            step();
        end
        $display("[TB] clear sweep: all 32 entries read back");

        for (int v = 0; v < 8; v++) begin
            we = vecs[v].we;
            rd = vecs[v].rd;
            di = vecs[v].di;
            ra = {vecs[v].ra1, vecs[v].ra0};
            @(negedge clk);
            chk("vec_a0", {32'h0, qa_a[31:0]},  {32'h0, vecs[v].exp_a0});
            chk("vec_a1", {32'h0, qa_a[63:32]}, {32'h0, vecs[v].exp_a1});
            chk("vec_b0", {32'h0, qa_b[31:0]},  {32'h0, vecs[v].exp_b0});
            chk("vec_b1", {32'h0, qa_b[63:32]}, {32'h0, vecs[v].exp_b1});
            model_check();
            @(posedge clk);
            model_update();
            #1;
            $display("[TB] vec %0d we=%0b rd=%0d di=%h ra0=%0d ra1=%0d qa_a=%h qa_b=%h",
                     v, vecs[v].we, vecs[v].rd, vecs[v].di, vecs[v].ra0, vecs[v].ra1, qa_a, qa_b);
        end
        we = 1'b0;

        // reset re-asserted 10 cycles into a clear sweep; writes during clear are dropped
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            we = (i < 33);
            rd = 5'd9;
            di = 32'hCAFEF00D;
            ra = {5'd9, 5'd9};
            #1;
            chk("midclr_ready", {63'h0, ready_a}, 64'(i == 33));
            if (i < 33) chk("midclr_qa", qa_a, 64'h0);
            step();
        end
        we = 1'b0;
        ra = {5'd9, 5'd9};
        #1;
        chk("midclr_wr_dropped", qa_a, 64'h0);
        $display("[TB] mid-clear reset: ready after 32 cycles, clear-time write dropped");

        // wide / shallow / three-port instance without a zero register
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_c = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            ra_c = 12'($urandom);
            #1;
            chk("p_clr_ready", {63'h0, ready_c}, 64'(i == 17));
            if (i < 17) begin
                for (int k = 0; k < 3; k++) chk("p_clr_qa", qa_c[k*64 +: 64], 64'h0);
            end
            @(posedge clk);
            #1;
        end
        we_c = 1'b1;
        rd_c = 4'd0;
        di_c = 64'hFFFF_0000_FFFF_0000;
        ra_c = 12'h0;
        #1;
        for (int k = 0; k < 3; k++) chk("p_bypass_x0", qa_c[k*64 +: 64], 64'hFFFF_0000_FFFF_0000);
        @(posedge clk);
        #1;
        we_c = 1'b0;
        di_c = 64'h0;
        #1;
        for (int k = 0; k < 3; k++) chk("p_read_x0", qa_c[k*64 +: 64], 64'hFFFF_0000_FFFF_0000);
        $display("[TB] param instance: 16-cycle clear, x0 write visible on all 3 ports");

        // randomized regression against the reference model
        for (int blk = 0; blk < 10; blk++) begin
            for (int c = 0; c < 1000; c++) begin
                rst = ($urandom_range(0, 199) == 0);
                we  = 1'($urandom);
                rd  = 5'($urandom);
                di  = $urandom;
                for (int k = 0; k < 2; k++) begin
                    if ($urandom_range(0, 3) == 0) ra[k*5 +: 5] = rd;
                    else ra[k*5 +: 5] = 5'($urandom);
                end
                step();
            end
            $display("[TB] random block %0d: 1000 cycles, %0d failures so far", blk, n_fail);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
